// File: rtl/mips_pkg.sv
// Shared constants for the instruction-memory path: word/byte widths, the HALT
// marker, the loader state encoding and the address-width helper.
package mips_pkg;

  localparam int NB_DATA = 32;
  localparam int NB_BYTE = 8;
  localparam logic [NB_DATA-1:0] HALT_WORD = 32'hFFFF_FFFF;

  localparam logic [1:0] LD_IDLE  = 2'd0;
  localparam logic [1:0] LD_RECV  = 2'd1;
  localparam logic [1:0] LD_WRITE = 2'd2;
  localparam logic [1:0] LD_DONE  = 2'd3;

  // Number of bits needed to represent value, so clogb2(2048) = 12.
  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value;
    for (r = 0; v > 0; r++) v = v >> 1;
    return r;
  endfunction

endpackage

// File: rtl/instruction_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface instruction_loader_if
  import mips_pkg::*;
#(
  parameter int ADDR_W = 12
);

  // A byte moves on a rising edge where i_byte_valid and o_byte_ready are both
  // high. o_byte_ready never depends on i_byte_valid; the source may raise or
  // drop valid in any cycle and must hold i_byte steady while valid waits.
  logic [NB_BYTE-1:0] i_byte;
  logic               i_byte_valid;
  logic               o_byte_ready;
  logic               o_wr_enable;
  logic [ADDR_W-1:0]  o_wr_addr;
  logic [NB_DATA-1:0] o_wr_data;

  modport master (
    output i_byte, i_byte_valid,
    input  o_byte_ready, o_wr_enable, o_wr_addr, o_wr_data
  );

  modport slave (
    input  i_byte, i_byte_valid,
    output o_byte_ready, o_wr_enable, o_wr_addr, o_wr_data
  );

endinterface

// File: rtl/word_packer.sv
// Shifts accepted bytes into a word, first byte ending up in the MSBs, and
// flags the byte that completes the word.
module word_packer
  import mips_pkg::*;
(
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_clear,
  input  logic               i_shift,
  input  logic [NB_BYTE-1:0] i_byte,
  output logic [NB_DATA-1:0] o_word,
  output logic               o_word_complete
);

  localparam int N_BYTES = NB_DATA / NB_BYTE;
  localparam int CNT_W   = $clog2(N_BYTES);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(N_BYTES - 1);

  logic [CNT_W-1:0] byte_cnt;

  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      byte_cnt <= '0;
      o_word   <= '0;
    end else if (i_shift) begin
      o_word   <= {o_word[NB_DATA-NB_BYTE-1:0], i_byte};
      byte_cnt <= (byte_cnt == LAST_BYTE) ? '0 : byte_cnt + 1'b1;
    end
  end

  assign o_word_complete = i_shift && (byte_cnt == LAST_BYTE);

endmodule

// File: rtl/instruction_loader.sv
// Packs a byte stream into instruction words and writes them to sequential
// addresses from 0 until a HALT word arrives or the memory is full.
module instruction_loader
  import mips_pkg::*;
#(
  parameter int N_ADDR             = 2048,
  parameter int LOG2_N_INSMEM_ADDR = clogb2(N_ADDR)
)(
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_start,
  instruction_loader_if.slave         bus,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_overflow,
  output logic [LOG2_N_INSMEM_ADDR:0] o_word_count,
  output logic [1:0]                  o_dbg_state
);

  localparam logic [LOG2_N_INSMEM_ADDR-1:0] LAST_ADDR = LOG2_N_INSMEM_ADDR'(N_ADDR - 1);

  logic [1:0]                        state, next_state;
  logic [LOG2_N_INSMEM_ADDR-1:0]     ptr, ptr_d;
  logic [LOG2_N_INSMEM_ADDR:0]       count_d;
  logic                              done_d, ovf_d, busy_d, ready_d, wr_en_d;
  logic                              ready_q, wr_en_q;
  logic                              accept, packer_clear, word_complete;
  logic                              start_session, is_halt, at_last;
  logic [NB_DATA-1:0]                word;

  assign accept        = bus.i_byte_valid && ready_q;
  assign packer_clear  = (state == LD_IDLE) || (state == LD_DONE);
  assign start_session = packer_clear && i_start;
  assign is_halt       = (word == HALT_WORD);
  assign at_last       = (ptr == LAST_ADDR);

  word_packer u_packer (
    .i_clock         (i_clock),
    .i_reset         (i_reset),
    .i_clear         (packer_clear),
    .i_shift         (accept),
    .i_byte          (bus.i_byte),
    .o_word          (word),
    .o_word_complete (word_complete)
  );

  // State and every output are flops; the comb blocks only compute next values.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state        <= LD_IDLE;
      ptr          <= '0;
      o_word_count <= '0;
      o_done       <= 1'b0;
      o_overflow   <= 1'b0;
      o_busy       <= 1'b0;
      ready_q      <= 1'b0;
      wr_en_q      <= 1'b0;
    end else begin
      state        <= next_state;
      ptr          <= ptr_d;
      o_word_count <= count_d;
      o_done       <= done_d;
      o_overflow   <= ovf_d;
      o_busy       <= busy_d;
      ready_q      <= ready_d;
      wr_en_q      <= wr_en_d;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      LD_IDLE, LD_DONE: if (i_start) next_state = LD_RECV;
      LD_RECV:          if (word_complete) next_state = LD_WRITE;
      LD_WRITE:         next_state = (is_halt || at_last) ? LD_DONE : LD_RECV;
      default:          next_state = LD_IDLE;
    endcase
  end

  always_comb begin
    busy_d  = (next_state == LD_RECV) || (next_state == LD_WRITE);
    ready_d = (next_state == LD_RECV);
    wr_en_d = (next_state == LD_WRITE);
    ptr_d   = ptr;
    count_d = o_word_count;
    done_d  = o_done;
    ovf_d   = o_overflow;
    if (start_session) begin
      ptr_d   = '0;
      count_d = '0;
      done_d  = 1'b0;
      ovf_d   = 1'b0;
    end
    // HALT takes priority: a HALT landing in the last slot is not an overflow.
    if (state == LD_WRITE) begin
      count_d = o_word_count + 1'b1;
      if (is_halt) begin
        done_d = 1'b1;
      end else if (at_last) begin
        done_d = 1'b1;
        ovf_d  = 1'b1;
      end else begin
        ptr_d = ptr + 1'b1;
      end
    end
  end

  assign bus.o_byte_ready = ready_q;
  assign bus.o_wr_enable  = wr_en_q;
  assign bus.o_wr_addr    = ptr;
  assign bus.o_wr_data    = word;
  assign o_dbg_state      = state;

endmodule
